// File: rtl/stream_fifo.sv
// Valid/ready circular stream buffer of DEPTH words with an occupancy count.
// Define STREAM_FIFO_FALLTHROUGH_EN to let a word pass straight through an empty buffer.
module stream_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;

    // Full/empty come from the count so pointer equality is never ambiguous.
    assign empty    = (cnt == '0);
    assign in_ready = (cnt != FULL);
    assign count    = cnt;

`ifdef STREAM_FIFO_FALLTHROUGH_EN
    // An empty buffer forwards the upstream word; if it is taken immediately nothing is stored.
    assign out_valid = empty ? in_valid : 1'b1;
    assign out_data  = empty ? in_data : mem[rptr];
    assign bypass    = empty && in_valid && out_ready;
`else
    assign out_valid = !empty;
    assign out_data  = mem[rptr];
    assign bypass    = 1'b0;
`endif

    assign push = in_valid && in_ready && !bypass;
    assign pop  = out_valid && out_ready && !bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Storage has no reset; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a reference model feeds a scoreboard queue on every
// accepted word, and an independent monitor pops and checks every emitted word.
module tb_stream_fifo;

    localparam int N     = 32;
    localparam int DEPTH = 4;
`ifdef STREAM_FIFO_FALLTHROUGH_EN
    localparam int STREAM_CNT = 0;
`else
    localparam int STREAM_CNT = 1;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   count;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [N-1:0] sb [$];
    int           modelCount = 0;
    bit           expValid;
    bit           modelBypass;
    bit           modelPush;
    bit           modelPop;
    logic [N-1:0] expWord;

    stream_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int expCount, input bit expReady,
                               input bit expVld);
        compare({name, " count"}, 64'(count), 64'(expCount));
        compare({name, " in_ready"}, 64'(in_ready), 64'(expReady));
        compare({name, " out_valid"}, 64'(out_valid), 64'(expVld));
    endtask

    task automatic applyStimulus(input bit iv, input logic [N-1:0] d, input bit ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: predicts the handshake at the coming edge and queues accepted words.
    always @(negedge clk) begin
        if (rst) begin
            modelCount = 0;
            sb.delete();
        end else begin
            expValid    = (modelCount != 0);
            modelBypass = 1'b0;
`ifdef STREAM_FIFO_FALLTHROUGH_EN
            if (modelCount == 0) begin
                expValid    = in_valid;
                modelBypass = in_valid && out_ready;
            end
`endif
            compare("model in_ready", 64'(in_ready), 64'(modelCount != DEPTH));
            compare("model count", 64'(count), 64'(modelCount));
            compare("model out_valid", 64'(out_valid), 64'(expValid));
            modelPush = in_valid && (modelCount != DEPTH);
            modelPop  = expValid && out_ready;
            if (modelPush) begin
                sb.push_back(in_data);
            end
            if (!modelBypass) begin
                modelCount = modelCount + int'(modelPush) - int'(modelPop);
            end
        end
    end

    // Monitor: every word the DUT hands downstream must match the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                compare("spurious out_valid", 64'(out_valid), 64'(0));
            end else begin
                expWord = sb.pop_front();
                compare("scoreboard out_data", 64'(out_data), 64'(expWord));
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("idle", 0, 1'b1, 1'b0);
        end

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, N'(i), 1'b0);
            step();
            checkOutput("fill", i, (i != 4), 1'b1);
        end

        applyStimulus(1'b1, 32'h5, 1'b0);
        step();
        step();
        checkOutput("blocked", 4, 1'b0, 1'b1);
        compare("blocked head", 64'(out_data), 64'h1);

        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            compare("drain data", 64'(out_data), 64'(i));
            step();
        end
        checkOutput("drained", 0, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, N'(32'hA0 + i), 1'b1);
            step();
            checkOutput("stream", STREAM_CNT, 1'b1, 1'b1);
            compare("stream data", 64'(out_data), 64'(32'hA0 + i));
        end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("stream end", 0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, N'(32'hB0 + i), 1'b0);
            step();
        end
        checkOutput("refill", 4, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hB4, 1'b1);
        step();
        checkOutput("full pop", 3, 1'b1, 1'b1);
        compare("full pop head", 64'(out_data), 64'hB1);
        step();
        checkOutput("full pop push", 3, 1'b1, 1'b1);
        compare("full pop push head", 64'(out_data), 64'hB2);
        applyStimulus(1'b0, '0, 1'b1);
        repeat (3) step();
        checkOutput("full drain", 0, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'hC0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hC1, 1'b0);
        step();
        checkOutput("pre reset", 2, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hC2, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post reset", 0, 1'b1, 1'b0);
        repeat (3) step();
        checkOutput("post reset idle", 0, 1'b1, 1'b0);

        step();
        compare("scoreboard drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parameterised valid/ready stream buffer that sits directly downstream of a `bar`-style stream interface, which exposes `data[N-1:0]`, `valid` and `ready`. It consumes the interface's data/valid and drives its ready, decoupling the producer from a downstream consumer through a circular buffer of `DEPTH` entries. It re-presents the buffered words on an identical valid/ready output port and exports an occupancy count for flow-control monitoring.

## Interface
- `N`, default 32: data width in bits; ≥1.
- `DEPTH`, default 4: number of storage entries; power of two, ≥2.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_data`  input  N  upstream word (from the interface's `data`).
- `in_valid`  input  1  upstream word present.
- `in_ready`  output  1  buffer can accept a word this cycle (drives the interface's `ready`).
- `out_data`  output  N  head-of-buffer word.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  downstream accepts `out_data` this cycle.
- `count`  output  $clog2(DEPTH+1)  number of stored words, 0..DEPTH.

## Operation
- Push: `in_valid && in_ready` at a rising edge. Write `in_data` at the write pointer, advance it.
- Pop: `out_valid && out_ready` at a rising edge. Advance the read pointer.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case. Full and empty are derived from `count`, never from pointer equality.
- `count` next value:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop in the same cycle, or on neither.
- `in_ready` = (`count` != DEPTH). It depends on registered state only and never combinationally on `out_ready`. When full, a same-cycle pop does not admit a push; the slot frees on the next cycle.
- `out_valid` = (`count` != 0), except in the fall-through case described under Configuration.
- `out_data` = storage[read pointer]. It is held stable while `out_valid && !out_ready`.
- `in_valid` while `in_ready`=0: no state change. The word is not dropped by the buffer; holding `in_valid` is the producer's responsibility.
- Storage contents are not reset. Only pointers and `count` are reset.
- Reset mid-operation:
  - In the cycle `rst` is sampled high, no push or pop takes effect.
  - Next cycle: pointers=0, `count`=0, `in_ready`=1, `out_valid`=0. Stored words are discarded.

## Timing
- Reset values: `count`=0, `in_ready`=1, `out_valid`=0. `out_data` is undefined (X permitted) while `out_valid`=0.
- Latency without fall-through: a word pushed at edge k appears with `out_valid`=1 after edge k. It is poppable at the earliest at edge k+1.
- Throughput: one push and one pop per cycle sustained whenever 0 < `count` < DEPTH.
- `in_ready` and `count` change only on clock edges.
- `out_valid` and `out_data` change only on clock edges, except in fall-through mode.

## Configuration
- Macro: `STREAM_FIFO_FALLTHROUGH_EN`.
- Defined:
  - While `count`=0, `out_valid`=`in_valid` and `out_data`=`in_data` combinationally.
  - If `out_ready`=1 in that cycle, push and pop cancel: no storage write, pointers and `count` unchanged, zero-cycle latency.
  - If `out_ready`=0, the word is pushed normally.
  - In all other states, behaviour is identical to the non-fall-through mode.
- Not defined: `out_valid` depends only on `count`, with a minimum one-cycle latency as above.
- `in_ready` behaviour is identical in both modes.

## Test plan
- Reset then idle (DEPTH=4, N=32): hold `rst`=1 for 2 cycles, then release. Expect `count`=0, `in_ready`=1, `out_valid`=0 for 5 idle cycles.
- Fill and block: `out_ready`=0, push 0x1, 0x2, 0x3, 0x4 on consecutive edges.
  - Expect `count` 1,2,3,4 and `in_ready`=0 after the 4th push.
  - A 5th word 0x5 held valid is not accepted until a pop occurs.
- Drain in order: from full, set `out_ready`=1. Expect `out_data` 0x1, 0x2, 0x3, 0x4 on consecutive cycles, then `out_valid`=0 and `count`=0.
- Wrap-around streaming: `in_valid`=`out_ready`=1 continuously for 10 words 0xA0..0xA9.
  - Expect in-order output and `count` steady at 1 after the first push (non-fall-through).
  - Expect `count` steady at 0 with fall-through.
- Full plus simultaneous pop: at `count`=4, `in_valid`=`out_ready`=1. Expect a pop with no push that cycle (`count`=3). The push is accepted on the next edge (`count` stays 3).
- Reset mid-stream: at `count`=2, assert `rst` together with `in_valid` and `out_ready`. Expect `count`=0 and `out_valid`=0 next cycle, with no word emitted after reset.
